draw_sequencer: RTL

- Runs the lab's drawing engines (fillscreen, circle, reuleaux) one at a time, in a fixed order, using each engine's start/done handshake.
- Routes the active engine's pixel stream to the single VGA adapter plot port, so the top level instantiates one sequencer instead of hand-muxing engines.
- Sits between the engines and the `vga_adapter` instance, inside the task top level.

---
 rtl/draw_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: runs fill/circle/reuleaux engines in order 0->1->2 and muxes the active one onto the VGA plot port.
// Optional RUN watchdog enabled by defining DRAW_SEQ_TIMEOUT_EN (limit set by TIMEOUT).
module draw_sequencer #(
   parameter int TIMEOUT = 20000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [2:0]  en_mask_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        timeout_err_o,
   output logic [2:0]  eng_start_o,
   input  logic [2:0]  eng_done_i,
   input  logic [23:0] eng_x_i,
   input  logic [20:0] eng_y_i,
   input  logic [8:0]  eng_colour_i,
   input  logic [2:0]  eng_plot_i,
   output logic [7:0]  vga_x_o,
   output logic [6:0]  vga_y_o,
   output logic [2:0]  vga_colour_o,
   output logic        vga_plot_o
);
   typedef enum logic [2:0] {IDLE, SEL, RUN, RELEASE, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  cur_q, cur_d;
   logic [2:0]  pending_q, pending_d;
   logic        run, done_cur, to_hit;
   assign run      = state_q == RUN;
   assign done_cur = eng_done_i[cur_q];
`ifdef DRAW_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;
   logic          err_q;
   assign to_hit        = run && !done_cur && (cnt_q == CW'(TIMEOUT - 1));
   assign timeout_err_o = err_q;
   // counter is held at zero outside RUN, so it is cleared on every entry to RUN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= run ? cnt_q + CW'(1) : '0;
         err_q <= (state_q == IDLE && start_i) ? 1'b0 : (err_q | to_hit);
      end
   end
`else
   assign to_hit        = 1'b0;
   assign timeout_err_o = 1'b0;
`endif
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         cur_q     <= 2'd0;
         pending_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         pending_q <= pending_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: if (start_i) begin
            pending_d = en_mask_i;
            state_d   = SEL;
         end
         SEL: if (pending_q == 3'd0) state_d = DONE;
         else begin
            cur_d   = pending_q[0] ? 2'd0 : pending_q[1] ? 2'd1 : 2'd2;
            state_d = RUN;
         end
         RUN: if (done_cur || to_hit) begin
            pending_d[cur_q] = 1'b0;
            state_d          = RELEASE;
         end
         RELEASE: if (!done_cur) state_d = SEL;
         DONE: if (!start_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign busy_o       = state_q == SEL || run || state_q == RELEASE;
   assign done_o       = state_q == DONE;
   assign eng_start_o  = run ? 3'b001 << cur_q : 3'b000;
   assign vga_x_o      = !run ? 8'd0 : cur_q == 2'd2 ? eng_x_i[23:16] : cur_q == 2'd1 ? eng_x_i[15:8] : eng_x_i[7:0];
   assign vga_y_o      = !run ? 7'd0 : cur_q == 2'd2 ? eng_y_i[20:14] : cur_q == 2'd1 ? eng_y_i[13:7] : eng_y_i[6:0];
   assign vga_colour_o = !run ? 3'd0 : cur_q == 2'd2 ? eng_colour_i[8:6] : cur_q == 2'd1 ? eng_colour_i[5:3] : eng_colour_i[2:0];
   assign vga_plot_o   = run && eng_plot_i[cur_q];
endmodule
